// File: rtl/demux8_pkg.sv
// Shared constants, state encoding and lane decode for the 1-to-8 word deserializer.
package demux8_pkg;

  localparam int LANES   = 8;
  localparam int LANE_AW = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_AW-1:0] lane);
    lane_onehot       = '0;
    lane_onehot[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/demux8_lane_reg.sv
// One output lane: enable-load register, cleared only by the async reset.
module lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/demux8_deser.sv
// 1-to-8 word deserializer: steers handshaked words into eight lanes and
// presents the completed line as one frame with its own handshake.
//
//   state | meaning
//   FILL  | accepting words; lane_mask tracks lanes written this frame
//   HOLD  | all eight lanes fresh; frame offered on q0..q7 until taken
module demux8_deser
  import demux8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_addr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [7:0]       lane_mask,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t               state, state_nxt;
  logic [LANE_AW-1:0]   ptr, ptr_nxt;
  logic [LANES-1:0]     mask, mask_nxt;
  logic                 accept;
  logic [LANE_AW-1:0]   tgt;
  logic [LANES-1:0]     tgt_onehot;
  logic [LANES-1:0]     lane_en;
  logic [WIDTH-1:0]     lane_q [LANES];

  assign in_ready   = (state == FILL) && !clr;
  assign out_valid  = (state == HOLD);
  assign lane_mask  = mask;
  assign accept     = in_valid && in_ready;
  assign tgt        = (mode == MODE_ADDR) ? in_addr : ptr;
  assign tgt_onehot = lane_onehot(tgt);
  // Gating with accept keeps in_addr/in_data don't-cares off the enables.
  assign lane_en    = accept ? tgt_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      ptr   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      mask  <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mask_nxt  = mask;
    if (clr) begin
      state_nxt = FILL;
      ptr_nxt   = '0;
      mask_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            mask_nxt = mask | tgt_onehot;
            if (mode == MODE_SEQ) ptr_nxt = ptr + 3'd1;
            if (mask_nxt == '1) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = FILL;
            ptr_nxt   = '0;
            mask_nxt  = '0;
          end
        end
        default: begin
          state_nxt = FILL;
          ptr_nxt   = '0;
          mask_nxt  = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (lane_en[i]),
      .d     (in_data),
      .q     (lane_q[i])
    );
  end

  assign q0 = lane_q[0];
  assign q1 = lane_q[1];
  assign q2 = lane_q[2];
  assign q3 = lane_q[3];
  assign q4 = lane_q[4];
  assign q5 = lane_q[5];
  assign q6 = lane_q[6];
  assign q7 = lane_q[7];

endmodule

// File: tb/tb_demux8_deser.sv
// Self-checking bench for demux8_deser: per-cycle model plus a frame scoreboard.
module tb_demux8_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_addr = '0;
  logic [7:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0] lane_mask;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic        m_hold = 1'b0;
  logic [2:0]  m_ptr = '0;
  logic [7:0]  m_mask = '0;
  logic [7:0]  m_q [8];
  logic [63:0] frame_q [$];

  always #5 clk = ~clk;

  demux8_deser #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .lane_mask(lane_mask), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_line();
    logic [63:0] l;
    for (int i = 0; i < 8; i++) l[i*8 +: 8] = m_q[i];
    return l;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = '0;
    m_mask = '0;
    for (int i = 0; i < 8; i++) m_q[i] = '0;
    frame_q.delete();
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance the model, cross the edge.
  task automatic beat(input logic v, input logic [7:0] d, input logic [2:0] a,
                      input logic m, input logic c, input logic ordy);
    logic [2:0]  tgt;
    logic [63:0] exp_frame;
    in_valid = v; in_data = d; in_addr = a; mode = m; clr = c; out_ready = ordy;
    #1;
    check_eq("in_ready", in_ready, !m_hold && !c);
    check_eq("out_valid", out_valid, m_hold);
    check_eq("lane_mask", lane_mask, m_mask);
    check_eq("q_lanes", {q7, q6, q5, q4, q3, q2, q1, q0}, model_line());
    if (out_valid && ordy && !c) begin
      if (frame_q.size() == 0) check_eq("frame_unexpected", 64'd1, 64'd0);
      else begin
        exp_frame = frame_q.pop_front();
        check_eq("frame", {q7, q6, q5, q4, q3, q2, q1, q0}, exp_frame);
      end
    end
    if (c) begin
      if (m_hold && frame_q.size() != 0) void'(frame_q.pop_front());
      m_hold = 1'b0; m_ptr = '0; m_mask = '0;
    end else if (!m_hold) begin
      if (v) begin
        tgt = m ? a : m_ptr;
        m_q[tgt] = d;
        m_mask[tgt] = 1'b1;
        if (!m) m_ptr = m_ptr + 3'd1;
        if (m_mask == 8'hFF) begin
          m_hold = 1'b1;
          frame_q.push_back(model_line());
        end
      end
    end else if (ordy) begin
      m_hold = 1'b0; m_ptr = '0; m_mask = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] addrs [9];
    logic [7:0] datas [9];
    addrs = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    datas = '{8'hA7, 8'hA3, 8'hB3, 8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6};
    model_reset();

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_lane_mask", lane_mask, 8'h00);
    check_eq("rst_q", {q7, q6, q5, q4, q3, q2, q1, q0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sequential fill, then back-pressure with in_valid held high
    for (int i = 0; i < 8; i++) beat(1'b1, 8'h10 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    check_eq("seq_q_direct", {q7, q6, q5, q4, q3, q2, q1, q0}, 64'h1716151413121110);
    for (int i = 0; i < 5; i++) beat(1'b1, 8'h55, 3'd0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 8'h55, 3'd0, 1'b0, 1'b0, 1'b1);
    check_eq("release_mask", lane_mask, 8'h00);
    check_eq("release_ready", in_ready, 1'b1);

    // addressed fill with overwrite of lane 3
    for (int i = 0; i < 9; i++) begin
      beat(1'b1, datas[i], addrs[i], 1'b1, 1'b0, 1'b0);
      if (i == 7) check_eq("addr_not_full_yet", out_valid, 1'b0);
    end
    check_eq("addr_q3", q3, 8'hB3);
    beat(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);

    // abort after three sequential words; the clr-cycle word is dropped
    for (int i = 0; i < 3; i++) beat(1'b1, 8'h30 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 8'hEE, 3'd0, 1'b0, 1'b1, 1'b0);
    check_eq("abort_mask", lane_mask, 8'h00);

    // mixed mode: sequential lanes 0-3, addressed lanes 4-7
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h70 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    check_eq("abort_q0", q0, 8'h70);
    for (int i = 4; i < 8; i++) beat(1'b1, 8'hC0 + 8'(i), 3'(i), 1'b1, 1'b0, 1'b0);
    check_eq("mixed_out_valid", out_valid, 1'b1);
    beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // async reset mid-cycle while in HOLD
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_lane_mask", lane_mask, 8'h00);
    check_eq("arst_q", {q7, q6, q5, q4, q3, q2, q1, q0}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) beat(1'b1, 8'h90 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check_eq("scoreboard_empty", 64'(frame_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
